// File: rtl/mario_obj_scan_if.sv
// Sprite hit-record stream from the object-table scanner to the line-buffer renderer.
interface mario_obj_scan_if;
    logic       spr_valid;
    logic       spr_rdy;
    logic [7:0] spr_code;
    logic [7:0] spr_attr;
    logic [7:0] spr_x;
    logic [3:0] spr_row;

    modport master (
        output spr_valid, spr_code, spr_attr, spr_x, spr_row,
        input  spr_rdy
    );

    modport slave (
        input  spr_valid, spr_code, spr_attr, spr_x, spr_row,
        output spr_rdy
    );
endinterface

// File: rtl/mario_obj_scan.sv
// Sprite object table (DMA destination) plus per-scanline scanner that streams
// the sprites intersecting the next line to the renderer.
module mario_obj_scan #(
    parameter int unsigned N_ENTRIES = 96,
    parameter int unsigned MAX_HITS  = 16,
    parameter int unsigned SPR_H     = 16
) (
    input  logic                    I_CLK_48M,
    input  logic                    I_RESET,
    input  logic                    I_CEN_12M,
    input  logic [9:0]              I_DMAD_A,
    input  logic [7:0]              I_DMAD_D,
    input  logic                    I_DMAD_CE,
    input  logic                    I_LINE_START,
    input  logic [7:0]              I_VPOS,
    mario_obj_scan_if.master        o_spr,
    output logic                    O_SCAN_BUSY,
    output logic                    O_SCAN_DONE,
    output logic                    O_OVF
);

    localparam int unsigned EW = $clog2(N_ENTRIES);
    localparam int unsigned HW = $clog2(MAX_HITS + 1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_CMP, S_EMIT, S_DONE} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [7:0]    r_mem_y [N_ENTRIES];
    logic [7:0]    r_mem_c [N_ENTRIES];
    logic [7:0]    r_mem_a [N_ENTRIES];
    logic [7:0]    r_mem_x [N_ENTRIES];
    logic [7:0]    r_rd_y, r_rd_c, r_rd_a, r_rd_x;
    logic [7:0]    r_tgt;
    logic [EW-1:0] r_entry;
    logic [HW-1:0] r_hits;
    logic          r_limit;
    logic [EW-1:0] w_wr_entry;
    logic [7:0]    w_row;
    logic          w_hit, w_last, w_accept, w_adv, w_set_ovf, w_enter_limit, w_load;

    assign w_wr_entry = I_DMAD_A[EW+1:2];
    assign w_row      = r_tgt - r_rd_y;
    assign w_hit      = (r_rd_y != 8'h00) && (w_row < 8'(SPR_H));
    assign w_last     = (r_entry == EW'(N_ENTRIES - 1));
    assign w_accept   = (r_state == S_EMIT) && o_spr.spr_valid && o_spr.spr_rdy;

    // Table storage; the registered read gives read-before-write on a same-entry collision.
    always_ff @(posedge I_CLK_48M) begin
        if (I_DMAD_CE && (I_DMAD_A < 10'(4 * N_ENTRIES))) begin
            case (I_DMAD_A[1:0])
                2'd0:    r_mem_y[w_wr_entry] <= I_DMAD_D;
                2'd1:    r_mem_c[w_wr_entry] <= I_DMAD_D;
                2'd2:    r_mem_a[w_wr_entry] <= I_DMAD_D;
                default: r_mem_x[w_wr_entry] <= I_DMAD_D;
            endcase
        end
        if ((r_state == S_FETCH) && I_CEN_12M) begin
            r_rd_y <= r_mem_y[r_entry];
            r_rd_c <= r_mem_c[r_entry];
            r_rd_a <= r_mem_a[r_entry];
            r_rd_x <= r_mem_x[r_entry];
        end
    end

    // Next-state logic; a line start restarts the scan from any state.
    always_comb begin
        w_state_nxt   = r_state;
        w_adv         = 1'b0;
        w_set_ovf     = 1'b0;
        w_enter_limit = 1'b0;
        w_load        = 1'b0;
        case (r_state)
            S_IDLE: w_state_nxt = S_IDLE;
            S_FETCH: begin
                if (I_CEN_12M) w_state_nxt = S_CMP;
            end
            S_CMP: begin
                if (I_CEN_12M) begin
                    if (w_hit && r_limit) begin
                        w_set_ovf   = 1'b1;
                        w_state_nxt = S_DONE;
                    end else if (w_hit) begin
                        w_load      = 1'b1;
                        w_state_nxt = S_EMIT;
                    end else if (w_last) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_adv       = 1'b1;
                        w_state_nxt = S_FETCH;
                    end
                end
            end
            S_EMIT: begin
                if (w_accept) begin
                    w_enter_limit = (r_hits == HW'(MAX_HITS - 1));
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_adv       = 1'b1;
                        w_state_nxt = S_FETCH;
                    end
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (I_LINE_START) w_state_nxt = S_FETCH;
    end

    always_ff @(posedge I_CLK_48M) begin
        if (I_RESET) begin
            r_state          <= S_IDLE;
            r_tgt            <= 8'h00;
            r_entry          <= '0;
            r_hits           <= '0;
            r_limit          <= 1'b0;
            O_SCAN_BUSY      <= 1'b0;
            O_SCAN_DONE      <= 1'b0;
            O_OVF            <= 1'b0;
            o_spr.spr_valid  <= 1'b0;
            o_spr.spr_code   <= 8'h00;
            o_spr.spr_attr   <= 8'h00;
            o_spr.spr_x      <= 8'h00;
            o_spr.spr_row    <= 4'h0;
        end else begin
            r_state         <= w_state_nxt;
            O_SCAN_BUSY     <= (w_state_nxt == S_FETCH) || (w_state_nxt == S_CMP) ||
                               (w_state_nxt == S_EMIT);
            O_SCAN_DONE     <= (w_state_nxt == S_DONE);
            o_spr.spr_valid <= (w_state_nxt == S_EMIT);
            if (I_LINE_START) begin
                r_tgt   <= I_VPOS + 8'd1;
                r_entry <= '0;
                r_hits  <= '0;
                r_limit <= 1'b0;
                O_OVF   <= 1'b0;
            end else begin
                if (w_load) begin
                    o_spr.spr_code <= r_rd_c;
                    o_spr.spr_attr <= r_rd_a;
                    o_spr.spr_x    <= r_rd_x;
                    o_spr.spr_row  <= w_row[3:0];
                end
                if (w_adv)         r_entry <= r_entry + EW'(1);
                if (w_accept)      r_hits  <= r_hits + HW'(1);
                if (w_enter_limit) r_limit <= 1'b1;
                if (w_set_ovf)     O_OVF   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mario_obj_scan.sv
// Bench for mario_obj_scan: directed scenarios plus randomized tables checked
// against a per-line hit-list model.
module tb_mario_obj_scan;

    logic       clk = 1'b0;
    logic       rst, cen, dce, ls;
    logic [9:0] da;
    logic [7:0] dd, vpos;
    logic       busy, done, ovf;
    int         total = 0;
    int         bad = 0;
    int         cen_cnt = 0;

    logic [7:0]  ty [96];
    logic [7:0]  tc [96];
    logic [7:0]  ta [96];
    logic [7:0]  tx [96];
    logic [27:0] expq [$];
    logic [27:0] gotq [$];
    logic        exp_ovf;

    mario_obj_scan_if u_if ();

    mario_obj_scan u_dut (
        .I_CLK_48M    (clk),
        .I_RESET      (rst),
        .I_CEN_12M    (cen),
        .I_DMAD_A     (da),
        .I_DMAD_D     (dd),
        .I_DMAD_CE    (dce),
        .I_LINE_START (ls),
        .I_VPOS       (vpos),
        .o_spr        (u_if),
        .O_SCAN_BUSY  (busy),
        .O_SCAN_DONE  (done),
        .O_OVF        (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge; scan enable is 1 in 4 clocks.
    task automatic tick();
        @(negedge clk);
        cen_cnt++;
        cen = (cen_cnt % 4 == 0);
    endtask

    function automatic logic [27:0] rec();
        return {u_if.spr_code, u_if.spr_attr, u_if.spr_x, u_if.spr_row};
    endfunction

    function automatic void clear_table();
        for (int i = 0; i < 96; i++) begin
            ty[i] = 8'h00; tc[i] = 8'h00; ta[i] = 8'h00; tx[i] = 8'h00;
        end
    endfunction

    // Full 384-byte DMA, then writes above the table that alias entry 5 if not ignored.
    task automatic load_table();
        for (int a = 0; a < 384; a++) begin
            tick();
            da  = 10'(a);
            dce = 1'b1;
            case (a % 4)
                0:       dd = ty[a / 4];
                1:       dd = tc[a / 4];
                2:       dd = ta[a / 4];
                default: dd = tx[a / 4];
            endcase
        end
        for (int a = 532; a < 536; a++) begin
            tick();
            da = 10'(a);
            dd = 8'h3C;
        end
        tick();
        dce = 1'b0;
    endtask

    // Hits in table order: Y nonzero and (line - Y) mod 256 below sprite height; beyond 16 is overflow.
    function automatic void model(input logic [7:0] v);
        logic [7:0] tgt;
        logic [7:0] row;
        int         n;
        n = 0;
        expq.delete();
        exp_ovf = 1'b0;
        tgt = v + 8'd1;
        for (int i = 0; i < 96; i++) begin
            row = tgt - ty[i];
            if (ty[i] != 8'h00 && row < 8'd16) begin
                if (n < 16) expq.push_back({tc[i], ta[i], tx[i], row[3:0]});
                else        exp_ovf = 1'b1;
                n++;
            end
        end
    endfunction

    task automatic run_scan(input logic [7:0] v, input int rdy_pct, input int stall,
                            input int abort_after, input logic [7:0] v2, input string tag);
        logic        pend;
        logic [27:0] prec;
        int          stall_left;
        bit          fin;
        bit          aborted;
        pend = 1'b0;
        prec = '0;
        stall_left = stall;
        fin = 1'b0;
        aborted = (abort_after == 0);
        gotq.delete();
        model(v);
        tick();
        ls = 1'b1;
        vpos = v;
        u_if.spr_rdy = 1'b0;
        tick();
        ls = 1'b0;
        chk({tag, ".busy_on"}, 32'(busy), 32'd1);
        for (int c = 0; c < 8000 && !fin; c++) begin
            tick();
            if (ls) begin
                ls = 1'b0;
                chk({tag, ".abort_valid"}, 32'(u_if.spr_valid), 32'd0);
                chk({tag, ".abort_done"}, 32'(done), 32'd0);
                chk({tag, ".abort_busy"}, 32'(busy), 32'd1);
            end else if (pend) begin
                chk({tag, ".hold_valid"}, 32'(u_if.spr_valid), 32'd1);
                chk({tag, ".hold_rec"}, 32'(rec()), 32'(prec));
            end
            if (done) begin
                fin = 1'b1;
                u_if.spr_rdy = 1'b0;
            end else if (!aborted && gotq.size() == abort_after && u_if.spr_valid) begin
                ls = 1'b1;
                vpos = v2;
                u_if.spr_rdy = 1'b1;
                aborted = 1'b1;
                pend = 1'b0;
                gotq.delete();
                model(v2);
            end else begin
                if (u_if.spr_valid && stall_left > 0) begin
                    u_if.spr_rdy = 1'b0;
                    stall_left--;
                end else begin
                    u_if.spr_rdy = ($urandom_range(99) < 32'(rdy_pct));
                end
                if (u_if.spr_valid && u_if.spr_rdy) begin
                    gotq.push_back(rec());
                    pend = 1'b0;
                end else begin
                    pend = u_if.spr_valid;
                    prec = rec();
                end
            end
        end
        chk({tag, ".done_seen"}, 32'(fin), 32'd1);
        chk({tag, ".busy_at_done"}, 32'(busy), 32'd0);
        chk({tag, ".ovf"}, 32'(ovf), 32'(exp_ovf));
        chk({tag, ".count"}, 32'(gotq.size()), 32'(expq.size()));
        for (int i = 0; i < expq.size() && i < gotq.size(); i++)
            chk($sformatf("%s.rec%0d", tag, i), 32'(gotq[i]), 32'(expq[i]));
        tick();
        chk({tag, ".done_pulse"}, 32'(done), 32'd0);
        chk({tag, ".ovf_held"}, 32'(ovf), 32'(exp_ovf));
    endtask

    initial begin
        rst = 1'b1; cen = 1'b0; dce = 1'b0; ls = 1'b0;
        da = '0; dd = '0; vpos = '0;
        u_if.spr_rdy = 1'b0;
        tick();
        tick();
        chk("rst.valid", 32'(u_if.spr_valid), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.ovf", 32'(ovf), 32'd0);
        chk("rst.rec", 32'(rec()), 32'd0);
        rst = 1'b0;

        clear_table();
        load_table();
        run_scan(8'h20, 100, 0, 0, 8'h00, "empty");

        ty[5] = 8'h40; tc[5] = 8'h12; ta[5] = 8'h03; tx[5] = 8'h80;
        load_table();
        run_scan(8'h44, 100, 0, 0, 8'h00, "single");
        chk("single.row5", 32'(expq.size() == 1 ? expq[0][3:0] : 4'hF), 32'd5);

        clear_table();
        for (int i = 0; i < 16; i++) begin ty[i] = 8'h10; tc[i] = 8'(i); tx[i] = 8'(3 * i); end
        load_table();
        run_scan(8'h10, 100, 0, 0, 8'h00, "hits16");
        for (int i = 16; i < 20; i++) begin ty[i] = 8'h10; tc[i] = 8'(i); tx[i] = 8'(3 * i); end
        load_table();
        run_scan(8'h10, 100, 0, 0, 8'h00, "hits20");

        run_scan(8'h12, 70, 10, 0, 8'h00, "stall");

        clear_table();
        ty[0] = 8'hFA; tc[0] = 8'hA1; ta[0] = 8'h40; tx[0] = 8'h10;
        ty[1] = 8'hF0; tc[1] = 8'hA2; ta[1] = 8'h80; tx[1] = 8'h20;
        ty[95] = 8'hF1; tc[95] = 8'hA3; ta[95] = 8'h01; tx[95] = 8'hFF;
        load_table();
        run_scan(8'h02, 100, 0, 0, 8'h00, "wrap_a");
        run_scan(8'hFF, 100, 0, 0, 8'h00, "wrap_b");

        clear_table();
        for (int i = 0; i < 10; i++) begin ty[i] = 8'h30 + 8'(i); tc[i] = 8'h50 + 8'(i); end
        load_table();
        run_scan(8'h38, 100, 0, 3, 8'h3A, "abort");

        for (int r = 0; r < 5; r++) begin
            logic [7:0] v;
            v = 8'($urandom_range(255));
            for (int i = 0; i < 96; i++) begin
                ty[i] = ($urandom_range(99) < 40) ? 8'h00 : v - 8'($urandom_range(24));
                tc[i] = 8'($urandom);
                ta[i] = 8'($urandom);
                tx[i] = 8'($urandom);
            end
            load_table();
            run_scan(v, 60, 0, 0, 8'h00, $sformatf("rand%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
